// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// fetch_stage: owns the PC, issues single-outstanding requests to instruction
// memory, holds the IF/ID instruction register and the EX/MEM instruction
// history used by the decoder's forwarding logic.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] pc_id,
  output logic        id_valid,
  output logic [31:0] ex_int_forward,
  output logic [31:0] mem_int_forward
);

  // REQ: ready to issue, WAIT: request outstanding, FULL: skid buffer holds a word
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  logic [1:0]  state_q,    state_d;
  logic [31:0] pc_q,       pc_d;
  logic        discard_q,  discard_d;
  logic [31:0] skid_q,     skid_d;
  logic [31:0] instr_q,    instr_d;
  logic [31:0] pc_id_q,    pc_id_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] ex_q,       ex_d;
  logic [31:0] mem_q,      mem_d;

  logic [31:0] redirect_aligned;
  logic [31:0] pc_inc;
  logic        load_id;
  logic [31:0] load_word;

  // Gated with rst_n so no request leaks out while reset is held.
  assign imem_req        = rst_n && (state_q == S_REQ) && !redirect_valid;
  assign imem_addr       = pc_q;
  assign instruction     = instr_q;
  assign pc_id           = pc_id_q;
  assign id_valid        = id_valid_q;
  assign ex_int_forward  = ex_q;
  assign mem_int_forward = mem_q;

  // Next-state logic: fetch FSM, PC update, ID register and history chain.
  always_comb begin
    redirect_aligned = {redirect_pc[31:2], 2'b00};
    pc_inc           = pc_q + 32'd4;
    state_d          = state_q;
    pc_d             = pc_q;
    discard_d        = discard_q;
    skid_d           = skid_q;
    instr_d          = instr_q;
    pc_id_d          = pc_id_q;
    id_valid_d       = id_valid_q;
    load_id          = 1'b0;
    load_word        = NOP;

    // The redirecting instruction still moves on to EX; only a stall bubbles it.
    mem_d = ex_q;
    ex_d  = stall ? NOP : instr_q;

    case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_aligned;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_aligned;
          if (imem_valid) begin
            state_d   = S_REQ;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end else if (imem_valid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else if (!stall) begin
            load_id   = 1'b1;
            load_word = imem_rdata;
            pc_d      = pc_inc;
            state_d   = S_REQ;
          end else begin
            skid_d  = imem_rdata;
            state_d = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (redirect_valid) begin
          pc_d    = redirect_aligned;
          state_d = S_REQ;
        end else if (!stall) begin
          load_id   = 1'b1;
          load_word = skid_q;
          pc_d      = pc_inc;
          state_d   = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    if (redirect_valid) begin
      instr_d    = NOP;
      id_valid_d = 1'b0;
    end else if (load_id) begin
      instr_d    = load_word;
      pc_id_d    = pc_q;
      id_valid_d = 1'b1;
    end else if (!stall) begin
      instr_d    = NOP;
      id_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      discard_q  <= 1'b0;
      skid_q     <= NOP;
      instr_q    <= NOP;
      pc_id_q    <= 32'h0000_0000;
      id_valid_q <= 1'b0;
      ex_q       <= NOP;
      mem_q      <= NOP;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      skid_q     <= skid_d;
      instr_q    <= instr_d;
      pc_id_q    <= pc_id_d;
      id_valid_q <= id_valid_d;
      ex_q       <= ex_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and instruction-history pipeline for the pipelined MIPS CPU. It owns the PC, issues requests to instruction memory, and holds the IF/ID instruction register that drives the control decoder's `instruction` input. It also produces the one-back (`ex_int_forward`) and two-back (`mem_int_forward`) instruction copies that the decoder's forwarding logic consumes. It supports hazard stalls, bubble insertion and PC redirects from jump, jr and bltz resolution.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `NOP`, 32'h0000_0000, bubble word inserted on flush, stall or fetch starvation.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  one-cycle request pulse to instruction memory.
- `imem_addr`  out  32  fetch address, equal to the current PC.
- `imem_valid`  in  1  response strobe, asserted at least 1 cycle after `imem_req`.
- `imem_rdata`  in  32  fetched word, valid when `imem_valid` is high.
- `stall`  in  1  hazard stall: hold ID, inject a bubble into EX.
- `redirect_valid`  in  1  taken jump or branch: change the PC and flush ID.
- `redirect_pc`  in  32  new PC, word-aligned.
- `instruction`  out  32  IF/ID instruction register; feeds the control decoder.
- `pc_id`  out  32  PC of `instruction`.
- `id_valid`  out  1  1 when `instruction` is a fetched word, 0 when it is a bubble.
- `ex_int_forward`  out  32  instruction one stage back (EX).
- `mem_int_forward`  out  32  instruction two stages back (MEM).

## Operation
- **States.** REQ, WAIT, FULL. At most one memory request is outstanding.
- **REQ.**
  - `imem_req = !redirect_valid`, `imem_addr = pc_q`.
  - Next state is WAIT when a request was issued; otherwise the FSM stays in REQ with the new PC.
- **WAIT, `imem_valid` high.**
  - If `discard` is set: drop the word, clear `discard`, go to REQ.
  - Else if `!stall`: load the word into `instruction`, set `pc_id = pc_q`, `id_valid = 1`, `pc_q += 4`, go to REQ.
  - Else (`stall`): capture the word in the skid buffer, go to FULL.
- **FULL.** When `stall` deasserts: move the buffer into ID, `pc_q += 4`, go to REQ.
- **ID when no new word is loaded.**
  - If `stall`: ID holds its value.
  - Otherwise: `instruction = NOP`, `id_valid = 0` (starvation bubble).
- **Redirect.** Highest priority; effective in any state.
  - `pc_q = redirect_pc`, `instruction = NOP`, `id_valid = 0`, skid buffer invalidated.
  - In WAIT without a same-cycle `imem_valid`: set `discard` and stay in WAIT.
  - In WAIT with a same-cycle `imem_valid`: drop the word, go to REQ.
  - In FULL: go to REQ.
- **History chain.** Updated every cycle:
  - `mem_int_forward <= ex_int_forward`
  - `ex_int_forward <= stall ? NOP : instruction`, using the pre-edge ID value. This is independent of redirect: the redirecting instruction itself proceeds to EX.
- **Arithmetic.** PC increment is mod 2^32; `32'hFFFF_FFFC + 4` wraps to 0. Bits [1:0] of `redirect_pc` are forced to 0.

## Timing
- **Reset values** (asynchronous, while `rst_n` is low):
  - state = REQ, `pc_q = RESET_PC`, `imem_addr = RESET_PC`, `imem_req = 0`.
  - `instruction`, `ex_int_forward`, `mem_int_forward` = NOP.
  - `pc_id = 0`, `id_valid = 0`, `discard = 0`, buffer invalid.
- **First request.** The first `imem_req` is in the first cycle after `rst_n` rises.
- **Mid-operation reset.** Reset during WAIT abandons the outstanding request. A response arriving after reset release while in REQ is ignored.
- **Throughput.** With a 1-cycle memory, REQ is at cycle n, `imem_valid` at n+1, ID is updated at the n+1 edge, and the next REQ is at n+2. This gives 1 instruction per 2 cycles.
- **Stall.** Takes effect at the edge where it is sampled high: ID holds, EX receives a NOP.
- **Redirect latency.** A redirect sampled at edge k produces `imem_addr = redirect_pc` in cycle k+1 if the FSM is in REQ or FULL. If the FSM is in WAIT, the address changes after the discarded response returns.
- **Simultaneous stall and redirect.** ID flushes to NOP, EX receives NOP, the PC is redirected.

## Test plan
- **Reset and sequential fetch.** Release reset with a 1-cycle memory returning `0x2001_0005` at 0x0 and `0x0022_1823` at 0x4 → `imem_addr` sequence 0x0, 0x4, 0x8. `instruction` = 0x2001_0005 with `pc_id = 0`, then 0x0022_1823 with `pc_id = 4`. `id_valid` alternates 1,0 on starvation cycles. `ex_int_forward` and `mem_int_forward` trail `instruction` by 1 and 2 cycles.
- **Stall in WAIT.** Assert `stall` for 3 cycles while a response returns → word held in FULL, `instruction` unchanged, `ex_int_forward = NOP` for 3 cycles. After release, the word enters ID and `pc_q` advances by 4 exactly once.
- **Redirect with outstanding request.** 3-cycle memory; redirect to 0x100 one cycle after `imem_req` → the returned word is discarded and never reaches ID. The next `imem_addr` is 0x100 and the 0x100 word reaches ID with `pc_id = 0x100`.
- **Redirect and stall together while in FULL.** → `instruction = NOP`, `id_valid = 0`, `ex_int_forward = NOP`, buffer dropped, next request at `redirect_pc`.
- **PC wrap and alignment.** Redirect to 0xFFFF_FFFE → fetch at 0xFFFF_FFFC, then 0x0000_0000.
- **Mid-operation reset.** Assert `rst_n = 0` in WAIT → all outputs return to their reset values immediately. The late `imem_valid` is ignored, and fetch restarts at `RESET_PC`.
